controle_de_coordenadas: RTL and testbench
==========================================

Name: controle_de_coordenadas

Overview:
- Upstream stage of gerenciador_de_ataque.
- Turns raw board push-buttons into a debounced, wrap-around cursor (coordColuna, coordLinha) over the 5-column × 7-row LED matrix.
- Issues one clean, framed confirmar pulse per accepted shot.
- Optionally rejects shots on cells already lit in the current attack matrix (matriz0..4 fed back from gerenciador_de_ataque).

Parameters:
- DEBOUNCE_CICLOS, 16: consecutive stable cycles required before a button change is accepted. Board build overrides with a large value.
- NUM_COLUNAS, 5: column count. Cursor column range 0..NUM_COLUNAS-1.
- NUM_LINHAS, 7: row count. Cursor row range 0..NUM_LINHAS-1.

Ports:
- clock  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- enable  input  1  game-in-attack-phase; low clears cursor and FSM
- btn_cima  input  1  raw button, active-high, asynchronous to clock
- btn_baixo  input  1  raw button, active-high
- btn_esq  input  1  raw button, active-high
- btn_dir  input  1  raw button, active-high
- btn_confirmar  input  1  raw button, active-high
- matriz0..matriz4  input  7 each  current attack matrix; bit r of matrizc = cell (column c, row r) already lit
- coordColuna  output  3  cursor column
- coordLinha  output  3  cursor row
- confirmar  output  1  registered one-cycle shot pulse to gerenciador_de_ataque
- rejeitado  output  1  registered one-cycle pulse when a confirm is refused
- ocupado  output  1  high while FSM not in OCIOSO

Behaviour:
- Clocking and reset: one clock. reset is synchronous, active-high. reset=1 at posedge forces:
  - coordColuna=0, coordLinha=0
  - confirmar=0, rejeitado=0, ocupado=0
  - FSM=OCIOSO
  - all synchronizers, stable states and debounce counters cleared to 0
- Input path, per button:
  - 2-flop synchronizer feeding a debouncer.
  - Debouncer holds a stable level and a counter.
  - Counter increments while the synchronized level differs from the stable level. It resets to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CICLOS-1 and still differs, the stable level flips and the counter clears.
  - A 0→1 flip of the stable level produces a one-cycle event.
  - Latency from a clean press to its event: 2 + DEBOUNCE_CICLOS cycles, ±1.
  - Holding a button produces exactly one event. There is no auto-repeat.
- Cursor, updated only in OCIOSO with enable=1:
  - cima: row-1, wrapping 0→NUM_LINHAS-1.
  - baixo: row+1, wrapping NUM_LINHAS-1→0.
  - esq: column-1, wrapping 0→NUM_COLUNAS-1.
  - dir: column+1, wrapping NUM_COLUNAS-1→0.
  - cima+baixo in the same cycle: row unchanged. esq+dir in the same cycle: column unchanged.
  - A row move and a column move in the same cycle both apply.
  - Cursor changes appear on outputs the cycle after the event.
- FSM states: OCIOSO, PREP, PULSO, FIM.
  - OCIOSO + confirm event + enable + cell free → PREP.
    - Confirm has priority: move events in that same cycle are discarded.
  - OCIOSO + confirm event + enable + cell lit → stay OCIOSO, rejeitado=1 for one cycle.
  - PREP → PULSO → FIM → OCIOSO, unconditionally, one cycle each.
  - confirmar=1 exactly while in PULSO (registered, glitch-free).
  - coordColuna/coordLinha are frozen from PREP through FIM. This gives the downstream edge-sampled flops setup and hold margin.
  - Any button event arriving outside OCIOSO is dropped.
  - ocupado=1 in PREP, PULSO and FIM.
- Cell-lit lookup: mux matriz[coordColuna][coordLinha]. coordColuna is never ≥5 and coordLinha is never ≥7 by construction.
- enable=0, sampled each cycle:
  - next cycle FSM=OCIOSO, cursor=(0,0), confirmar=0, rejeitado=0.
  - Debouncers keep running, so a button held through an enable low→high transition yields no event.
- Reset or enable drop during PULSO: confirmar goes to 0 on the next edge. A truncated pulse is accepted.

Optional Feature:
- Macro: BLOQUEIO_REPETIDO_EN.
- Defined: the cell-lit check above is active.
- Undefined: every confirm in OCIOSO with enable=1 proceeds to PREP. rejeitado is tied to 0. matriz inputs are unused.

Test Plan:
All tests use DEBOUNCE_CICLOS=4.
1. reset=1 for 2 cycles, then enable=1, btn_dir held 20 cycles → coordColuna 0→1 exactly once, about 6 cycles after press. coordLinha stays 0.
2. Cursor at (0,0), one clean btn_esq press, then one btn_cima press → (4,0), then (4,6). Then 5 btn_dir presses → column returns to 4 via wrap 4→0.
3. btn_baixo glitch high for 3 cycles, repeated with 3-cycle gaps → no cursor change. Then held 10 cycles → coordLinha increments by 1.
4. Cursor (2,3), all matriz=0, btn_confirmar pressed → ocupado high 3 cycles. confirmar high exactly 1 cycle, in the 2nd of those cycles. Coordinates stay (2,3). A btn_dir event injected during PREP is ignored.
5. With BLOQUEIO_REPETIDO_EN: matriz2=7'b0001000, cursor (2,3), confirm → confirmar stays 0, rejeitado high 1 cycle, FSM stays OCIOSO. Without the macro, same stimulus → confirmar pulse as in test 4, rejeitado=0.
6. Cursor (3,5), confirm, then enable=0 in the PULSO cycle → next cycle confirmar=0, cursor (0,0), ocupado=0. Repeating with reset=1 instead of enable=0 gives the same result.

Source files
------------

// File: rtl/controle_de_coordenadas.sv
// Debounced push-button cursor over the LED matrix with a framed shot pulse.
// Define BLOQUEIO_REPETIDO_EN to refuse shots on cells already lit in matriz0..4.
module controle_de_coordenadas #(
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int NUM_COLUNAS     = 5,
  parameter int NUM_LINHAS      = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_cima,
  input  logic       btn_baixo,
  input  logic       btn_esq,
  input  logic       btn_dir,
  input  logic       btn_confirmar,
  input  logic [6:0] matriz0,
  input  logic [6:0] matriz1,
  input  logic [6:0] matriz2,
  input  logic [6:0] matriz3,
  input  logic [6:0] matriz4,
  output logic [2:0] coordColuna,
  output logic [2:0] coordLinha,
  output logic       confirmar,
  output logic       rejeitado,
  output logic       ocupado
);

  localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [2:0] COL_MAX = 3'(NUM_COLUNAS - 1);
  localparam logic [2:0] LIN_MAX = 3'(NUM_LINHAS - 1);

  typedef enum logic [1:0] {OCIOSO, PREP, PULSO, FIM} estado_t;

  estado_t    r_estado, w_estado_next;
  logic [2:0] r_col, r_lin, w_col_next, w_lin_next;
  logic       r_confirmar, r_rejeitado, r_ocupado;
  logic       w_rejeita, w_celula_acesa;
  logic [4:0] w_btn, w_evento;

  // bit order: 0 cima, 1 baixo, 2 esq, 3 dir, 4 confirmar
  assign w_btn = {btn_confirmar, btn_dir, btn_esq, btn_baixo, btn_cima};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_debounce
      logic          r_sync0, r_sync1, r_estavel, r_ev;
      logic [CW-1:0] r_cont;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_sync0   <= 1'b0;
          r_sync1   <= 1'b0;
          r_estavel <= 1'b0;
          r_cont    <= '0;
          r_ev      <= 1'b0;
        end else begin
          r_sync0 <= w_btn[gi];
          r_sync1 <= r_sync0;
          r_ev    <= 1'b0;
          if (r_sync1 == r_estavel) begin
            r_cont <= '0;
          end else if (r_cont == CW'(DEBOUNCE_CICLOS - 1)) begin
            r_estavel <= r_sync1;
            r_cont    <= '0;
            r_ev      <= r_sync1;
          end else begin
            r_cont <= r_cont + CW'(1);
          end
        end
      end

      assign w_evento[gi] = r_ev;
    end
  endgenerate

`ifdef BLOQUEIO_REPETIDO_EN
  logic [6:0] w_matriz [0:4];
  assign w_matriz[0] = matriz0;
  assign w_matriz[1] = matriz1;
  assign w_matriz[2] = matriz2;
  assign w_matriz[3] = matriz3;
  assign w_matriz[4] = matriz4;
  assign w_celula_acesa = w_matriz[r_col][r_lin];
`else
  logic w_unused_matriz;
  assign w_unused_matriz = ^{matriz0, matriz1, matriz2, matriz3, matriz4};
  assign w_celula_acesa  = 1'b0;
`endif

  always_comb begin
    w_estado_next = r_estado;
    w_col_next    = r_col;
    w_lin_next    = r_lin;
    w_rejeita     = 1'b0;
    if (!enable) begin
      w_estado_next = OCIOSO;
      w_col_next    = '0;
      w_lin_next    = '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          // a confirm swallows any move arriving in the same cycle
          if (w_evento[4]) begin
            if (w_celula_acesa) w_rejeita = 1'b1;
            else                w_estado_next = PREP;
          end else begin
            if (w_evento[0] && !w_evento[1])
              w_lin_next = (r_lin == 3'd0) ? LIN_MAX : r_lin - 3'd1;
            else if (w_evento[1] && !w_evento[0])
              w_lin_next = (r_lin == LIN_MAX) ? 3'd0 : r_lin + 3'd1;
            if (w_evento[2] && !w_evento[3])
              w_col_next = (r_col == 3'd0) ? COL_MAX : r_col - 3'd1;
            else if (w_evento[3] && !w_evento[2])
              w_col_next = (r_col == COL_MAX) ? 3'd0 : r_col + 3'd1;
          end
        end
        PREP:    w_estado_next = PULSO;
        PULSO:   w_estado_next = FIM;
        FIM:     w_estado_next = OCIOSO;
        default: w_estado_next = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_col       <= '0;
      r_lin       <= '0;
      r_confirmar <= 1'b0;
      r_rejeitado <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      r_estado    <= w_estado_next;
      r_col       <= w_col_next;
      r_lin       <= w_lin_next;
      r_confirmar <= (w_estado_next == PULSO);
      r_rejeitado <= w_rejeita;
      r_ocupado   <= (w_estado_next != OCIOSO);
    end
  end

  assign coordColuna = r_col;
  assign coordLinha  = r_lin;
  assign confirmar   = r_confirmar;
  assign rejeitado   = r_rejeitado;
  assign ocupado     = r_ocupado;

endmodule

// File: tb/tb_controle_de_coordenadas.sv
// Directed bench for controle_de_coordenadas with DEBOUNCE_CICLOS=4.
module tb_controle_de_coordenadas;

  logic       clock = 1'b0;
  logic       reset, enable;
  logic       btn_cima, btn_baixo, btn_esq, btn_dir, btn_confirmar;
  logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
  logic [2:0] coordColuna, coordLinha;
  logic       confirmar, rejeitado, ocupado;

  int checks = 0;
  int errors = 0;

`ifdef BLOQUEIO_REPETIDO_EN
  localparam int LIT_CONF = 0;
  localparam int LIT_REJ  = 1;
`else
  localparam int LIT_CONF = 1;
  localparam int LIT_REJ  = 0;
`endif

  controle_de_coordenadas #(.DEBOUNCE_CICLOS(4), .NUM_COLUNAS(5), .NUM_LINHAS(7)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .btn_cima(btn_cima), .btn_baixo(btn_baixo), .btn_esq(btn_esq),
    .btn_dir(btn_dir), .btn_confirmar(btn_confirmar),
    .matriz0(matriz0), .matriz1(matriz1), .matriz2(matriz2),
    .matriz3(matriz3), .matriz4(matriz4),
    .coordColuna(coordColuna), .coordLinha(coordLinha),
    .confirmar(confirmar), .rejeitado(rejeitado), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] mask;   // 0 cima, 1 baixo, 2 esq, 3 dir, 4 confirmar
    logic [6:0] m2;
    logic [6:0] m3;
    int         col;
    int         lin;
    int         conf;
    int         rej;
  } vec_t;

  vec_t tbl [21];
  int   nconf, nrej, nocu;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    {btn_confirmar, btn_dir, btn_esq, btn_baixo, btn_cima} = m;
  endtask

  // press, hold, release and let both debouncer and FSM settle, counting pulses
  task automatic press(input logic [4:0] m, input int hold);
    nconf = 0; nrej = 0; nocu = 0;
    set_btns(m);
    for (int i = 0; i < hold + 12; i++) begin
      if (i == hold) set_btns(5'b0);
      tick();
      nconf += int'(confirmar);
      nrej  += int'(rejeitado);
      nocu  += int'(ocupado);
    end
  endtask

  initial begin
    int   t0, changes, lat;
    logic found;
    logic [2:0] prev_col;
    logic oc [24];
    logic cf [24];

    reset = 1'b1; enable = 1'b0; set_btns(5'b0);
    matriz0 = '0; matriz1 = '0; matriz2 = '0; matriz3 = '0; matriz4 = '0;

    // reset state
    tick(); tick();
    chk("reset_col", int'(coordColuna), 0);
    chk("reset_lin", int'(coordLinha), 0);
    chk("reset_confirmar", int'(confirmar), 0);
    chk("reset_rejeitado", int'(rejeitado), 0);
    chk("reset_ocupado", int'(ocupado), 0);
    $display("reset: col=%0d lin=%0d ocupado=%0d", coordColuna, coordLinha, ocupado);

    // held dir: exactly one step, roughly 2+DEBOUNCE+1 cycles later
    reset = 1'b0; enable = 1'b1;
    tick();
    btn_dir = 1'b1;
    changes = 0; lat = -1; prev_col = coordColuna;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (coordColuna != prev_col) begin
        changes++;
        if (lat < 0) lat = i;
      end
      prev_col = coordColuna;
    end
    btn_dir = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("hold_changes", changes, 1);
    chk("hold_col", int'(coordColuna), 1);
    chk("hold_lin", int'(coordLinha), 0);
    chk("hold_latency_ok", int'(lat >= 6 && lat <= 8), 1);
    $display("hold dir: changes=%0d latency=%0d col=%0d", changes, lat, coordColuna);

    reset = 1'b1; tick(); reset = 1'b0;
    chk("rereset_col", int'(coordColuna), 0);

    tbl[0]  = '{5'b00100, 7'd0, 7'd0, 4, 0, 0, 0};
    tbl[1]  = '{5'b00001, 7'd0, 7'd0, 4, 6, 0, 0};
    tbl[2]  = '{5'b01000, 7'd0, 7'd0, 0, 6, 0, 0};
    tbl[3]  = '{5'b01000, 7'd0, 7'd0, 1, 6, 0, 0};
    tbl[4]  = '{5'b01000, 7'd0, 7'd0, 2, 6, 0, 0};
    tbl[5]  = '{5'b01000, 7'd0, 7'd0, 3, 6, 0, 0};
    tbl[6]  = '{5'b01000, 7'd0, 7'd0, 4, 6, 0, 0};
    tbl[7]  = '{5'b00010, 7'd0, 7'd0, 4, 0, 0, 0};
    tbl[8]  = '{5'b01100, 7'd0, 7'd0, 4, 0, 0, 0};
    tbl[9]  = '{5'b00011, 7'd0, 7'd0, 4, 0, 0, 0};
    tbl[10] = '{5'b01001, 7'd0, 7'd0, 0, 6, 0, 0};
    tbl[11] = '{5'b00010, 7'd0, 7'd0, 0, 0, 0, 0};
    tbl[12] = '{5'b01000, 7'd0, 7'd0, 1, 0, 0, 0};
    tbl[13] = '{5'b01000, 7'd0, 7'd0, 2, 0, 0, 0};
    tbl[14] = '{5'b00010, 7'd0, 7'd0, 2, 1, 0, 0};
    tbl[15] = '{5'b00010, 7'd0, 7'd0, 2, 2, 0, 0};
    tbl[16] = '{5'b00010, 7'd0, 7'd0, 2, 3, 0, 0};
    tbl[17] = '{5'b10000, 7'd0, 7'd0, 2, 3, 1, 0};
    tbl[18] = '{5'b10000, 7'b0001000, 7'd0, 2, 3, LIT_CONF, LIT_REJ};
    tbl[19] = '{5'b11000, 7'd0, 7'd0, 2, 3, 1, 0};
    tbl[20] = '{5'b10000, 7'b0000100, 7'b0001000, 2, 3, 1, 0};

    for (int v = 0; v < 21; v++) begin
      matriz2 = tbl[v].m2; matriz3 = tbl[v].m3;
      press(tbl[v].mask, 8);
      chk($sformatf("vec%0d_col", v), int'(coordColuna), tbl[v].col);
      chk($sformatf("vec%0d_lin", v), int'(coordLinha), tbl[v].lin);
      chk($sformatf("vec%0d_confirmar", v), nconf, tbl[v].conf);
      chk($sformatf("vec%0d_rejeitado", v), nrej, tbl[v].rej);
      chk($sformatf("vec%0d_ocupado", v), nocu, 3 * tbl[v].conf);
      $display("vec%0d mask=%b col=%0d lin=%0d conf=%0d rej=%0d ocu=%0d",
               v, tbl[v].mask, coordColuna, coordLinha, nconf, nrej, nocu);
    end
    matriz2 = '0; matriz3 = '0;

    // short glitches on baixo never pass the debouncer
    for (int r = 0; r < 4; r++) begin
      btn_baixo = 1'b1; tick(); tick(); tick();
      btn_baixo = 1'b0; tick(); tick(); tick();
    end
    for (int i = 0; i < 8; i++) tick();
    chk("glitch_lin", int'(coordLinha), 3);
    chk("glitch_col", int'(coordColuna), 2);
    press(5'b00010, 10);
    chk("held_baixo_lin", int'(coordLinha), 4);
    $display("glitch: lin after glitches=3 expected, after hold lin=%0d", coordLinha);

    // precise pulse framing; dir event lands one cycle after confirm (in PREP)
    btn_confirmar = 1'b1;
    tick();
    btn_dir = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      oc[i] = ocupado;
      cf[i] = confirmar;
    end
    set_btns(5'b0);
    for (int i = 0; i < 12; i++) tick();
    t0 = -1;
    for (int i = 0; i < 24; i++) if (oc[i] && t0 < 0) t0 = i;
    chk("frame_found", int'(t0 >= 3 && t0 <= 8), 1);
    if (t0 >= 3 && t0 <= 8) begin
      chk("frame_cf0", int'(cf[t0]), 0);
      chk("frame_cf1", int'(cf[t0+1]), 1);
      chk("frame_cf2", int'(cf[t0+2]), 0);
      chk("frame_oc1", int'(oc[t0+1]), 1);
      chk("frame_oc2", int'(oc[t0+2]), 1);
      chk("frame_oc3", int'(oc[t0+3]), 0);
    end
    chk("frame_col_frozen", int'(coordColuna), 2);
    chk("frame_lin_frozen", int'(coordLinha), 4);
    $display("frame: ocupado at %0d col=%0d lin=%0d", t0, coordColuna, coordLinha);

    // abort in PULSO: enable drop, then reset
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        press(5'b01000, 8); press(5'b00010, 8);     // (2,4) -> (3,5)
      end else begin
        press(5'b00001, 8); press(5'b00001, 8);     // (0,0) -> (0,5)
        press(5'b00100, 8); press(5'b00100, 8);     // -> (3,5)
      end
      chk($sformatf("abort%0d_start_col", pass), int'(coordColuna), 3);
      chk($sformatf("abort%0d_start_lin", pass), int'(coordLinha), 5);
      btn_confirmar = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
        tick();
        if (confirmar) found = 1'b1;
      end
      chk($sformatf("abort%0d_pulse_found", pass), int'(found), 1);
      if (pass == 0) enable = 1'b0; else reset = 1'b1;
      tick();
      chk($sformatf("abort%0d_confirmar", pass), int'(confirmar), 0);
      chk($sformatf("abort%0d_ocupado", pass), int'(ocupado), 0);
      chk($sformatf("abort%0d_col", pass), int'(coordColuna), 0);
      chk($sformatf("abort%0d_lin", pass), int'(coordLinha), 0);
      chk($sformatf("abort%0d_rejeitado", pass), int'(rejeitado), 0);
      $display("abort%0d: confirmar=%0d ocupado=%0d col=%0d lin=%0d",
               pass, confirmar, ocupado, coordColuna, coordLinha);
      btn_confirmar = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      enable = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
